// File: rtl/data_store_rmw.sv
// Store unit for a word-only data memory: sb/sh are done as read-modify-write,
// sw is a single write, and illegal requests report Misalign without touching memory.
module data_store_rmw #(
   parameter int READ_LAT = 1
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        Start,
   input  logic [31:0] Addr,
   input  logic [31:0] Din,
   input  logic [1:0]  store_option,
   input  logic [31:0] Mem_Dout,
   output logic [31:0] Mem_Addr,
   output logic [31:0] Mem_Din,
   output logic        Mem_Re,
   output logic        Mem_We,
   output logic [3:0]  Mem_Be,
   output logic        Busy,
   output logic        Done,
   output logic        Misalign
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READ  = 3'd1,
      S_WAIT  = 3'd2,
      S_WRITE = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam logic [2:0] LAT_C = 3'(READ_LAT);

   state_t      state_r, next_s;
   logic [2:0]  cnt_r;
   logic [31:0] a_r, d_r;
   logic [1:0]  opt_r;
   logic [31:0] a_s, d_s;
   logic [1:0]  opt_s;

   logic [31:0] mem_addr_r, mem_din_r, mem_addr_s, mem_din_s;
   logic        mem_re_r, mem_we_r, busy_r, done_r, misalign_r;
   logic        mem_re_s, mem_we_s, busy_s, done_s, misalign_s;
   logic [3:0]  mem_be_r, mem_be_s;

   function automatic logic is_legal(input logic [1:0] opt, input logic [1:0] lo);
      case (opt)
         2'b00:   is_legal = 1'b1;
         2'b01:   is_legal = ~lo[0];
         2'b10:   is_legal = (lo == 2'b00);
         default: is_legal = 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] lane_be(input logic [1:0] opt, input logic [1:0] lo);
      case (opt)
         2'b00:   lane_be = 4'b0001 << lo;
         2'b01:   lane_be = lo[1] ? 4'b1100 : 4'b0011;
         2'b10:   lane_be = 4'b1111;
         default: lane_be = 4'b0000;
      endcase
   endfunction

   // Replace only the addressed lane(s) of the read word; upper Din bits are dropped for sb/sh.
   function automatic logic [31:0] merge_word(input logic [1:0] opt, input logic [1:0] lo,
                                              input logic [31:0] d, input logic [31:0] rd);
      logic [31:0] w;
      w = rd;
      case (opt)
         2'b00: begin
            case (lo)
               2'b00:   w[7:0]   = d[7:0];
               2'b01:   w[15:8]  = d[7:0];
               2'b10:   w[23:16] = d[7:0];
               2'b11:   w[31:24] = d[7:0];
               default: w = rd;
            endcase
         end
         2'b01: begin
            if (lo[1]) w[31:16] = d[15:0];
            else       w[15:0]  = d[15:0];
         end
         2'b10:   w = d;
         default: w = rd;
      endcase
      merge_word = w;
   endfunction

   // In IDLE the request has not been latched yet, so decisions use the live inputs.
   assign a_s   = (state_r == S_IDLE) ? Addr : a_r;
   assign d_s   = (state_r == S_IDLE) ? Din : d_r;
   assign opt_s = (state_r == S_IDLE) ? store_option : opt_r;

   // State, request latch and WAIT down-counter.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_r <= S_IDLE;
         cnt_r   <= 3'd0;
         a_r     <= 32'd0;
         d_r     <= 32'd0;
         opt_r   <= 2'b00;
      end else begin
         state_r <= next_s;
         if (state_r == S_IDLE && Start) begin
            a_r   <= Addr;
            d_r   <= Din;
            opt_r <= store_option;
         end
         if (state_r == S_READ)      cnt_r <= LAT_C;
         else if (state_r == S_WAIT) cnt_r <= cnt_r - 3'd1;
         else                        cnt_r <= cnt_r;
      end
   end

   // Next-state decode.
   always_comb begin
      next_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (!Start)                               next_s = S_IDLE;
            else if (!is_legal(store_option, Addr[1:0])) next_s = S_DONE;
            else if (store_option == 2'b10)           next_s = S_WRITE;
            else                                      next_s = S_READ;
         end
         S_READ:  next_s = S_WAIT;
         S_WAIT: begin
            if (cnt_r == 3'd1) next_s = S_WRITE;
            else               next_s = S_WAIT;
         end
         S_WRITE: next_s = S_DONE;
         S_DONE:  next_s = S_IDLE;
         default: next_s = S_IDLE;
      endcase
   end

   // Output values for the upcoming state; on WAIT->WRITE the merge consumes Mem_Dout directly.
   always_comb begin
      mem_re_s   = (next_s == S_READ);
      mem_we_s   = (next_s == S_WRITE);
      busy_s     = (next_s != S_IDLE);
      done_s     = (next_s == S_DONE);
      misalign_s = (next_s == S_DONE) && (state_r == S_IDLE);
      if (next_s == S_READ || next_s == S_WAIT || next_s == S_WRITE) mem_addr_s = {a_s[31:2], 2'b00};
      else                                                          mem_addr_s = 32'd0;
      if (next_s == S_WRITE) begin
         mem_be_s = lane_be(opt_s, a_s[1:0]);
         if (state_r == S_IDLE) mem_din_s = d_s;
         else                   mem_din_s = merge_word(opt_s, a_s[1:0], d_s, Mem_Dout);
      end else begin
         mem_be_s  = 4'b0000;
         mem_din_s = 32'd0;
      end
   end

   // Output registers; mem_din_r doubles as the merge register.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         mem_addr_r <= 32'd0;
         mem_din_r  <= 32'd0;
         mem_re_r   <= 1'b0;
         mem_we_r   <= 1'b0;
         mem_be_r   <= 4'b0000;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         misalign_r <= 1'b0;
      end else begin
         mem_addr_r <= mem_addr_s;
         mem_din_r  <= mem_din_s;
         mem_re_r   <= mem_re_s;
         mem_we_r   <= mem_we_s;
         mem_be_r   <= mem_be_s;
         busy_r     <= busy_s;
         done_r     <= done_s;
         misalign_r <= misalign_s;
      end
   end

   assign Mem_Addr = mem_addr_r;
   assign Mem_Din  = mem_din_r;
   assign Mem_Re   = mem_re_r;
   assign Mem_We   = mem_we_r;
   assign Mem_Be   = mem_be_r;
   assign Busy     = busy_r;
   assign Done     = done_r;
   assign Misalign = misalign_r;

endmodule

// File: doc/data_store_rmw.md
Name: data_store_rmw

Overview:
- Store-side counterpart of the load extension path in the multi-cycle CPU.
- Takes sb/sh/sw requests (address, rt data, store option) and drives a word-only data memory that has no byte enables.
- Full-word stores go straight to a single write. Sub-word stores do a read-modify-write: read the word, merge the byte or halfword lane, write it back.
- Misaligned or reserved requests are flagged and never touch memory.

Parameters:
READ_LAT, 1, memory read latency in cycles; Mem_Dout is valid exactly READ_LAT cycles after the Mem_Re cycle; legal range 1..7.

Ports:
Clk  input  1  system clock, rising edge
Rst  input  1  asynchronous, active-high reset
Start  input  1  request strobe, sampled only in IDLE
Addr  input  32  byte address of the store
Din  input  32  rt register value
store_option  input  2  00=sb, 01=sh, 10=sw, 11=reserved
Mem_Dout  input  32  memory read data
Mem_Addr  output  32  word-aligned address {A[31:2],2'b00}
Mem_Din  output  32  memory write data
Mem_Re  output  1  memory read strobe
Mem_We  output  1  memory write strobe
Mem_Be  output  4  byte lanes being modified (observability only)
Busy  output  1  high whenever state != IDLE
Done  output  1  one-cycle completion pulse
Misalign  output  1  one-cycle error pulse, coincident with Done

Behaviour:
- Reset value of every output is 0. State returns to IDLE.
- Reset is asynchronous and may land mid-operation: Mem_We and Mem_Re drop immediately, no partial write occurs, and the request is discarded.
- On Start in IDLE, the unit latches Addr, Din and store_option into A, D and OPT.
- Start is ignored while Busy=1; no queueing.
- All outputs are registered.
- States: IDLE, READ, WAIT, WRITE, DONE.
- Legality check in IDLE:
  - sh with Addr[0]=1 is illegal.
  - sw with Addr[1:0]!=0 is illegal.
  - option 11 is illegal.
  - Illegal request: IDLE -> DONE. In DONE, Done=1 and Misalign=1, with no Mem_Re or Mem_We in any cycle. Then DONE -> IDLE.
- sw path: IDLE -> WRITE -> DONE -> IDLE.
  - WRITE: Mem_We=1, Mem_Din=D, Mem_Be=4'b1111.
  - DONE: Done=1.
  - Done lands 2 cycles after the Start cycle.
- sb/sh path: IDLE -> READ -> WAIT -> WRITE -> DONE -> IDLE.
  - READ: Mem_Re=1 for exactly one cycle; Mem_Addr is valid.
  - WAIT: lasts READ_LAT cycles, tracked by a 3-bit down-counter loaded with READ_LAT on entry. Mem_Dout is captured into the merge register in the last WAIT cycle.
  - WRITE: Mem_We=1 for one cycle with the merged word.
  - DONE: Done=1.
  - Done lands 3+READ_LAT cycles after the Start cycle (4 with the default).
- Merge rules:
  - sb: lane k=A[1:0] takes D[7:0]; other lanes keep read data; Mem_Be=one-hot(k).
  - sh: A[1]=0 gives D[15:0] into bits [15:0]; A[1]=1 gives D[15:0] into bits [31:16]; the other half keeps read data. Mem_Be=0011 or 1100.
- Upper bits of Din are ignored for sb/sh.
- Mem_Addr holds the word address from READ through WRITE and returns to 0 in IDLE.
- Mem_Re and Mem_We are never high in the same cycle.
- Exactly one Mem_We pulse per legal request.
- A Start seen in the same cycle the unit returns to IDLE (the cycle after DONE) is accepted normally.

Test Plan:
- sw Addr=0x0000_0010, Din=0xDEAD_BEEF -> one Mem_We with Mem_Addr=0x10, Mem_Din=0xDEADBEEF, Be=1111; Done 2 cycles after Start; Mem_Re never high.
- sb Addr=0x0000_0022, Din=0x1234_56AB, memory returns 0x1111_1111 -> Mem_Re at cycle 1; Mem_We at cycle 3 with Mem_Addr=0x20, Mem_Din=0x11AB_1111, Be=0100; Done at cycle 4.
- sh Addr=0x0000_0042, Din=0xFFFF_CAFE, memory returns 0x0000_5555 -> Mem_Din=0xCAFE_5555, Be=1100. Repeat with READ_LAT=3: Done at cycle 6, merge uses data captured 3 cycles after Mem_Re.
- Misaligned sh Addr=0x0000_0001, then sw Addr=0x0000_0006, then option 11 -> each gives Done=Misalign=1 one cycle after Start; no Mem_Re or Mem_We.
- Start pulsed every cycle during an sb operation -> only the first is accepted; exactly one Mem_We. A Start in the cycle after DONE begins a new operation.
- Rst asserted during WAIT of an sb -> all outputs 0 asynchronously; no Mem_We ever. After release, an sw completes normally.
